// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns round stage, one captured state per block.
// Latency: out_valid rises 4/COLS_PER_CYCLE edges after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   in_valid/in_ready - handshake for state_in + last_round (SubBytes output)
//   state_in[127:0]   - post-SubBytes state, byte k at [127-8k -: 8], column-major
//   last_round        - 1 = ShiftRows only (final AES round)
//   out_valid/out_ready - handshake for state_out toward AddRoundKey
//   state_out[127:0]  - ShiftRows(+MixColumns) result, retained after handoff
//   busy              - high while a block is in BUSY or DONE
module shift_mix_stage #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("shift_mix_stage: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // Counter increment; modulo keeps it 2 bits wide (the 4-column case never
   // takes the increment branch because one cycle finishes the block).
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   fsm_t         state;
   logic [1:0]   col_cnt;
   logic [127:0] cap_state;
   logic         cap_last;

   logic [127:0] shifted;
   logic [31:0]  res_col [4];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column word holds row 0 in the top byte.
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] o0, o1, o2, o3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      o0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {o0, o1, o2, o3};
   endfunction

   // Full ShiftRows and per-column results from the captured state; the FSM
   // picks which columns land in state_out each BUSY cycle.
   always_comb begin
      shifted = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127-8*(4*c+r) -: 8] = cap_state[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         res_col[c] = cap_last ? shifted[127-32*c -: 32]
                               : mix_col(shifted[127-32*c -: 32]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col_cnt   <= 2'd0;
         cap_state <= '0;
         cap_last  <= 1'b0;
         state_out <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cap_state <= state_in;
                  cap_last  <= last_round;
                  col_cnt   <= 2'd0;
                  state     <= BUSY;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            BUSY: begin
               for (int c = 0; c < 4; c++) begin
                  if (c >= int'(col_cnt) && c < int'(col_cnt) + COLS_PER_CYCLE)
                     state_out[127-32*c -: 32] <= res_col[c];
               end
               if (int'(col_cnt) + COLS_PER_CYCLE >= 4) begin
                  col_cnt   <= 2'd0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  col_cnt <= col_cnt + COL_STEP;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               col_cnt   <= 2'd0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_mix_stage.sv
module tb_shift_mix_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         last_round;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   // wider instances share data/reset but have their own handshakes
   logic         in_valid_w;
   logic         in_ready_2, in_ready_4;
   logic         out_valid_2, out_valid_4;
   logic         out_ready_w;
   logic [127:0] state_out_2, state_out_4;
   logic         busy_2, busy_4;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [127:0] V_IN    = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V_MIX   = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] V_SR    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V_COLIN = {4{32'hdb135345}};
   localparam logic [127:0] V_COLOT = {4{32'h8e4da1bc}};
   localparam logic [127:0] V_C6    = {16{8'hc6}};

   always #5 clk = ~clk;

   shift_mix_stage #(.COLS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .state_in(state_in), .last_round(last_round), .out_valid(out_valid),
      .out_ready(out_ready), .state_out(state_out), .busy(busy));

   shift_mix_stage #(.COLS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_2),
      .state_in(state_in), .last_round(last_round), .out_valid(out_valid_2),
      .out_ready(out_ready_w), .state_out(state_out_2), .busy(busy_2));

   shift_mix_stage #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_4),
      .state_in(state_in), .last_round(last_round), .out_valid(out_valid_4),
      .out_ready(out_ready_w), .state_out(state_out_4), .busy(busy_4));

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [127:0] d, input logic lr);
      state_in   = d;
      last_round = lr;
      in_valid   = 1'b1;
      step();
      in_valid   = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if (state_out !== 128'h0) $display("FAIL reset_state_out got %h want 0", state_out); else pass_cnt++;
   endtask

   task automatic test_round(input logic [127:0] d, input logic lr,
                             input logic [127:0] exp, input string name);
      int n;
      accept(d, lr);
      total_cnt++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL %s_busy busy=%b in_ready=%b want 1/0", name, busy, in_ready);
      else pass_cnt++;
      wait_done(n);
      total_cnt++;
      if (n !== 4) $display("FAIL %s_latency got %0d want 4", name, n); else pass_cnt++;
      total_cnt++;
      if (state_out !== exp) $display("FAIL %s_data got %h want %h", name, state_out, exp); else pass_cnt++;
      handoff();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL %s_handoff in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int n;
      int bad;
      accept(V_IN, 1'b0);
      wait_done(n);
      total_cnt++;
      if (n !== 4) $display("FAIL bp_latency got %0d want 4", n); else pass_cnt++;
      // a competing block is offered throughout the stall and must be ignored
      state_in   = V_C6;
      last_round = 1'b1;
      in_valid   = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== V_MIX || busy !== 1'b1)
            bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL bp_hold unstable_cycles got %0d want 0", bad); else pass_cnt++;
      in_valid = 1'b0;
      handoff();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
      else pass_cnt++;
      step();
      step();
      total_cnt++;
      if (state_out !== V_MIX) $display("FAIL bp_retain got %h want %h", state_out, V_MIX); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      accept(V_IN, 1'b0);
      step();
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      total_cnt++;
      if (state_out !== 128'h0) $display("FAIL midrst_state_out got %h want 0", state_out); else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL midrst_ctrl out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      else pass_cnt++;
      test_round(V_IN, 1'b0, V_MIX, "after_rst");
   endtask

   task automatic test_wide();
      int n2 = -1;
      int n4 = -1;
      state_in   = V_IN;
      last_round = 1'b0;
      in_valid_w = 1'b1;
      step();
      in_valid_w = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (n4 < 0 && out_valid_4) n4 = i - 1;
         if (n2 < 0 && out_valid_2) n2 = i - 1;
         step();
      end
      total_cnt++;
      if (n2 !== 2) $display("FAIL cols2_latency got %0d want 2", n2); else pass_cnt++;
      total_cnt++;
      if (n4 !== 1) $display("FAIL cols4_latency got %0d want 1", n4); else pass_cnt++;
      total_cnt++;
      if (state_out_2 !== V_MIX) $display("FAIL cols2_data got %h want %h", state_out_2, V_MIX); else pass_cnt++;
      total_cnt++;
      if (state_out_4 !== V_MIX) $display("FAIL cols4_data got %h want %h", state_out_4, V_MIX); else pass_cnt++;
      out_ready_w = 1'b1;
      step();
      out_ready_w = 1'b0;
      total_cnt++;
      if (in_ready_2 !== 1'b1 || in_ready_4 !== 1'b1 || busy_2 !== 1'b0 || busy_4 !== 1'b0)
         $display("FAIL wide_handoff in_ready=%b%b busy=%b%b want 11/00", in_ready_2, in_ready_4, busy_2, busy_4);
      else pass_cnt++;
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_valid_w  = 1'b0;
      out_ready   = 1'b0;
      out_ready_w = 1'b0;
      state_in    = '0;
      last_round  = 1'b0;
      #2;
      test_reset();
      test_round(V_IN, 1'b0, V_MIX, "round1");
      test_round(V_IN, 1'b1, V_SR, "last_round");
      test_round(V_COLIN, 1'b0, V_COLOT, "col_db135345");
      test_round(V_C6, 1'b0, V_C6, "col_c6");
      test_backpressure();
      test_reset_mid();
      test_wide();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
